// File: rtl/sin_phase_seq_pkg.sv
// Purpose: shared synth constants, quadrant encoding and sample helpers for the sine voice.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
// Build option: SIN_OFFSET_OUT_EN selects offset-binary samples (idle value 32)
// instead of two's complement (idle value 0).
package sin_phase_seq_pkg;

  localparam int NBIT_PHASE_IDX = 7;   // 128 phase points per period
  localparam int N_VAL_SIN      = 32;  // quarter-wave ROM depth
  localparam int QUAD_IDX_W     = 5;   // index within one quadrant
  localparam int ROM_ADDR_W     = 6;
  localparam int ROM_DATA_W     = 6;
  localparam int SAMPLE_W       = 7;

  // Quadrant = top two bits of the phase index.
  typedef enum logic [1:0] {
    QUAD_RISE_POS = 2'd0,  // 0..90 deg   : direct index
    QUAD_FALL_POS = 2'd1,  // 90..180 deg : mirrored index
    QUAD_FALL_NEG = 2'd2,  // 180..270 deg: direct index, negated
    QUAD_RISE_NEG = 2'd3   // 270..360 deg: mirrored index, negated
  } quad_e;

  typedef struct packed {
    logic [ROM_ADDR_W-1:0] addr;
    logic                  neg;
  } quad_map_t;

`ifdef SIN_OFFSET_OUT_EN
  localparam logic [SAMPLE_W-1:0] SAMPLE_IDLE = 7'd32;
`else
  localparam logic [SAMPLE_W-1:0] SAMPLE_IDLE = 7'd0;
`endif

  // Rebuild a full-wave sample from a quarter-wave magnitude. Magnitude is at
  // most 31, so negation cannot overflow 7 bits. Adding SAMPLE_IDLE turns the
  // two's complement value into offset-binary when that build option is set.
  function automatic logic [SAMPLE_W-1:0] build_sample(input logic                  neg,
                                                       input logic [ROM_DATA_W-1:0] mag);
    logic [SAMPLE_W-1:0] mag_ext;
    logic [SAMPLE_W-1:0] val;
    mag_ext = {1'b0, mag};
    val     = neg ? (-mag_ext) : mag_ext;
    return val + SAMPLE_IDLE;
  endfunction

endpackage

// File: rtl/sin_quad_map.sv
// Purpose: maps a 7-bit phase index to a quarter-wave ROM address plus negate flag.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of phase_idx).
// Ports: phase_idx in [6:0]; qmap out {addr[5:0], neg}, addr bit 5 always 0.
module sin_quad_map
  import sin_phase_seq_pkg::*;
(
  input  logic [NBIT_PHASE_IDX-1:0] phase_idx,
  output quad_map_t                 qmap
);

  quad_e                 quad;
  logic [QUAD_IDX_W-1:0] idx;
  logic [QUAD_IDX_W-1:0] idx_mirror;

  assign quad       = quad_e'(phase_idx[NBIT_PHASE_IDX-1 -: 2]);
  assign idx        = phase_idx[QUAD_IDX_W-1:0];
  assign idx_mirror = QUAD_IDX_W'(N_VAL_SIN - 1) - idx;

  always_comb begin
    qmap = '0;
    case (quad)
      QUAD_RISE_POS: begin qmap.addr = {1'b0, idx};        qmap.neg = 1'b0; end
      QUAD_FALL_POS: begin qmap.addr = {1'b0, idx_mirror}; qmap.neg = 1'b0; end
      QUAD_FALL_NEG: begin qmap.addr = {1'b0, idx};        qmap.neg = 1'b1; end
      QUAD_RISE_NEG: begin qmap.addr = {1'b0, idx_mirror}; qmap.neg = 1'b1; end
      default:       begin qmap.addr = '0;                 qmap.neg = 1'b0; end
    endcase
  end

endmodule

// File: rtl/sin_phase_seq.sv
// Purpose: phase-accumulator sequencer driving a quarter-wave sine ROM, rebuilds full-wave samples.
// Latency: 2 cycles from sample_tick edge to sample_valid; one sample per cycle sustained.
// Backpressure: none; en=0 synchronously flushes the pipeline and restarts from phase 0.
// Ports: clk, rstn (async active-low), en, sample_tick, freq_word[FW_W-1:0],
//        rom_en/rom_addr[5:0] -> ROM, rom_data[5:0] <- ROM (registered, +1 cycle),
//        sample_out[6:0] + sample_valid -> mixer.
// Build option: SIN_OFFSET_OUT_EN gives offset-binary sample_out (see package).
module sin_phase_seq
  import sin_phase_seq_pkg::*;
#(
  parameter int PACC_W = 16,
  parameter int FW_W   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  sample_tick,
  input  logic [FW_W-1:0]       freq_word,
  output logic                  rom_en,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [ROM_DATA_W-1:0] rom_data,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_valid
);

  logic [PACC_W-1:0]         acc;
  logic [NBIT_PHASE_IDX-1:0] phase_idx;
  quad_map_t                 qmap;

  // Sign and valid travel alongside the ROM's own register stage.
  logic stage1_neg, stage1_vld;
  logic stage2_neg, stage2_vld;

  assign rom_en    = en;
  assign phase_idx = acc[PACC_W-1 -: NBIT_PHASE_IDX];

  sin_quad_map u_quad_map (
    .phase_idx (phase_idx),
    .qmap      (qmap)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc          <= '0;
      rom_addr     <= '0;
      stage1_neg   <= 1'b0;
      stage1_vld   <= 1'b0;
      stage2_neg   <= 1'b0;
      stage2_vld   <= 1'b0;
      sample_out   <= SAMPLE_IDLE;
      sample_valid <= 1'b0;
    end else if (!en) begin
      // Disable discards anything in flight and parks at phase 0.
      acc          <= '0;
      rom_addr     <= '0;
      stage1_neg   <= 1'b0;
      stage1_vld   <= 1'b0;
      stage2_neg   <= 1'b0;
      stage2_vld   <= 1'b0;
      sample_out   <= SAMPLE_IDLE;
      sample_valid <= 1'b0;
    end else begin
      stage1_vld <= sample_tick;
      if (sample_tick) begin
        // Address comes from the pre-increment phase.
        rom_addr   <= qmap.addr;
        stage1_neg <= qmap.neg;
        acc        <= acc + PACC_W'(freq_word);
      end
      stage2_neg   <= stage1_neg;
      stage2_vld   <= stage1_vld;
      sample_valid <= stage2_vld;
      if (stage2_vld) begin
        sample_out <= build_sample(stage2_neg, rom_data);
      end
    end
  end

endmodule

// File: tb/tb_sin_phase_seq.sv
// Purpose: self-checking bench for sin_phase_seq with a behavioural quarter-wave ROM.
// Latency: expects sample_valid exactly 2 cycles after each accepted tick.
// Backpressure: none; en drop / async reset flush the scoreboard.
module tb_sin_phase_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        sample_tick;
  logic [15:0] freq_word;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [5:0]  rom_data = '0;
  logic [6:0]  sample_out;
  logic        sample_valid;

  sin_phase_seq #(.PACC_W(16), .FW_W(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .en           (en),
    .sample_tick  (sample_tick),
    .freq_word    (freq_word),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // round(31*sin(i*pi/64)), i = 0..31
  int rom_tab [32];
  always @(posedge clk) if (rom_en) rom_data <= 6'(rom_tab[rom_addr[4:0]]);

  typedef struct { int exp; int due; } sb_t;
  sb_t sb_q[$];
  sb_t mon_e;
  int  spot[int];
  int  cyc = 0;
  int  rx_num = 0;
  int  rx_base = 0;
  int  acc_m = 0;
  int  n_chk = 0;
  int  n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int to_out(input int v);
`ifdef SIN_OFFSET_OUT_EN
    return v + 32;
`else
    return (v + 128) % 128;
`endif
  endfunction

  function automatic int exp_addr(input int p);
    int q, idx;
    q   = p / 32;
    idx = p % 32;
    return (q % 2 == 1) ? 31 - idx : idx;
  endfunction

  function automatic int exp_sample(input int p);
    int v;
    v = rom_tab[exp_addr(p)];
    if (p >= 64) v = -v;
    return to_out(v);
  endfunction

  // Scoreboard consumer: every valid must match the head entry and its due cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (sample_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", int'(sample_valid), 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sample", int'(sample_out), mon_e.exp);
          chk("latency", cyc, mon_e.due);
          if (spot.exists(rx_num - rx_base))
            chk("spot_sample", int'(sample_out), spot[rx_num - rx_base]);
          rx_num <= rx_num + 1;
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        chk("missing_valid", int'(sample_valid), 1);
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic step(input bit tick);
    int  a_exp;
    bit  acc_ok;
    sample_tick = tick;
    @(posedge clk);
    acc_ok = tick && en && rstn;
    if (!en || !rstn) begin
      sb_q.delete();
      acc_m = 0;
    end
    a_exp = 0;
    #1;
    if (acc_ok) begin
      a_exp = exp_addr((acc_m >> 9) & 127);
      sb_q.push_back('{exp: exp_sample((acc_m >> 9) & 127), due: cyc + 2});
      acc_m = (acc_m + int'(freq_word)) & 16'hFFFF;
      chk("rom_addr", int'(rom_addr), a_exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb_q.size() != 0; i++) step(1'b0);
    step(1'b0);
    chk("scoreboard_empty", sb_q.size(), 0);
  endtask

  task automatic new_test();
    rx_base = rx_num;
    spot.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rom_tab = '{0, 2, 3, 5, 6, 8, 9, 10, 12, 13, 15, 16, 17, 18, 20, 21,
                22, 23, 24, 25, 26, 27, 27, 28, 29, 29, 30, 30, 30, 31, 31, 31};
    rstn = 1'b0; en = 1'b0; sample_tick = 1'b0; freq_word = 16'h0200;

    // Reset held with ticks toggling.
    for (int i = 0; i < 4; i++) begin
      step(i[0]);
      chk("rst_sample_out", int'(sample_out), to_out(0));
      chk("rst_sample_valid", int'(sample_valid), 0);
      chk("rst_rom_addr", int'(rom_addr), 0);
    end
    rstn = 1'b1;
    en   = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("idle_sample_out", int'(sample_out), to_out(0));
    chk("idle_sample_valid", int'(sample_valid), 0);

    // freq_word 0x0200, tick every cycle: two full periods.
    new_test();
    spot[8] = to_out(12); spot[40] = to_out(28); spot[70] = to_out(-9);
    spot[127] = to_out(0); spot[136] = to_out(12);
    for (int i = 0; i < 256; i++) step(1'b1);
    drain();

    // freq_word 0x1000, tick every 3rd cycle: phase index steps by 8.
    en = 1'b0; step(1'b0); en = 1'b1;
    freq_word = 16'h1000;
    new_test();
    spot[4] = to_out(31); spot[12] = to_out(-31); spot[16] = to_out(0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1); step(1'b0); step(1'b0);
    end
    drain();

    // en dropped with two samples in flight.
    freq_word = 16'h0200;
    en = 1'b0; step(1'b0); en = 1'b1;
    step(1'b1); step(1'b1);
    step(1'b1); step(1'b1);
    en = 1'b0;
    step(1'b0);
    chk("en_drop_sample_out", int'(sample_out), to_out(0));
    chk("en_drop_valid", int'(sample_valid), 0);
    en = 1'b1;
    new_test();
    spot[0] = to_out(0); spot[1] = to_out(2);
    step(1'b1); step(1'b1);
    drain();

    // Async reset pulse mid-cycle while streaming.
    new_test();
    for (int i = 0; i < 12; i++) step(1'b1);
    sample_tick = 1'b0;
    #2;
    rstn = 1'b0;
    sb_q.delete();
    acc_m = 0;
    #1;
    chk("arst_sample_out", int'(sample_out), to_out(0));
    chk("arst_sample_valid", int'(sample_valid), 0);
    chk("arst_rom_addr", int'(rom_addr), 0);
    #4;
    rstn = 1'b1;
    new_test();
    spot[0] = to_out(0); spot[8] = to_out(12);
    for (int i = 0; i < 10; i++) step(1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
